dm_arbiter: RTL

//   Two-requester arbiter sequencing the single data-memory port (addr/op/we/wdata -> rdata).

---
 rtl/dm_arbiter.sv | 89 ++++++++
 1 files changed

// File: rtl/dm_arbiter.sv
// dm_arbiter: round-robin two-master arbiter sequencing one request/response access to the data memory
module dm_arbiter #(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [1:0]        req_valid,
  output logic [1:0]        req_ready,
  input  logic              req_we0,
  input  logic              req_we1,
  input  logic [1:0]        req_op0,
  input  logic [1:0]        req_op1,
  input  logic [ADDR_W-1:0] req_addr0,
  input  logic [ADDR_W-1:0] req_addr1,
  input  logic [DATA_W-1:0] req_wdata0,
  input  logic [DATA_W-1:0] req_wdata1,
  output logic [1:0]        rsp_valid,
  input  logic [1:0]        rsp_ready,
  output logic [DATA_W-1:0] rsp_rdata,
  output logic              rsp_err,
  output logic [ADDR_W-1:0] dm_addr,
  output logic [1:0]        dm_op,
  output logic              dm_we,
  output logic [DATA_W-1:0] dm_wdata,
  input  logic [DATA_W-1:0] dm_rdata
);
  typedef enum logic [1:0] {IDLE, ACCESS, RESP} state_t;
  state_t state_q, state_d;
  logic rr_q, rr_d, win, win_q, grant, access, err, we_q, err_q;
  logic [1:0] op_q;
  logic [ADDR_W-1:0] addr_q;
  logic [DATA_W-1:0] wdata_q, rdata_q;
  // Outputs are gated by reset so nothing reaches the memory in the reset cycle
  assign win = &req_valid ? rr_q : req_valid[1];
  assign grant = state_q == IDLE && |req_valid && !reset;
  assign access = state_q == ACCESS && !reset;
  assign err = op_q == 2'b11 || (op_q == 2'b10 && addr_q[0]) || (op_q == 2'b00 && addr_q[1:0] != 2'b00);
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= IDLE;
      rr_q <= 1'b0;
      win_q <= 1'b0;
      we_q <= 1'b0;
      op_q <= 2'b00;
      addr_q <= '0;
      wdata_q <= '0;
      rdata_q <= '0;
      err_q <= 1'b0;
    end else begin
      state_q <= state_d;
      rr_q <= rr_d;
      if (grant) begin
        win_q <= win;
        we_q <= win ? req_we1 : req_we0;
        op_q <= win ? req_op1 : req_op0;
        addr_q <= win ? req_addr1 : req_addr0;
        wdata_q <= win ? req_wdata1 : req_wdata0;
      end
      if (access) begin
        rdata_q <= dm_rdata;
        err_q <= err;
      end
    end
  end
  always_comb begin
    state_d = state_q;
    rr_d = rr_q;
    case (state_q)
      IDLE: state_d = grant ? ACCESS : IDLE;
      ACCESS: state_d = RESP;
      RESP: begin
        state_d = rsp_ready[win_q] ? IDLE : RESP;
        rr_d = rsp_ready[win_q] ? ~win_q : rr_q;
      end
      default: state_d = IDLE;
    endcase
  end
  always_comb begin
    req_ready = grant ? {win, ~win} : 2'b00;
    rsp_valid = (state_q == RESP && !reset) ? {win_q, ~win_q} : 2'b00;
    rsp_rdata = rdata_q;
    rsp_err = err_q;
    dm_addr = access ? addr_q : '0;
    dm_op = access ? op_q : 2'b00;
    dm_we = access && we_q && !err;
    dm_wdata = access ? wdata_q : '0;
  end
endmodule
